keypad_scan_db: RTL
===================

Name: keypad_scan_db

Overview:
- Parametrised keypad scanner and debouncer: drives ROWS active-low row selects and samples COLS active-low column inputs, which are already synchronised upstream.
- Emits a one-cycle key_valid strobe with a binary key code per debounced press.
- Keeps a HIST_DEPTH-deep history of codes for downstream multiplexed 7-segment display logic.
- Successor to the fixed 4x4 two-digit scanner; sits between the column synchroniser and the display mux in top.

Parameters:
- ROWS, 4, number of row lines driven (>=2).
- COLS, 4, number of column lines sampled (>=2).
- SCAN_DIV, 1000, clock cycles each row is driven before advancing (>=2).
- DEBOUNCE_CNT, 20000, consecutive stable cycles required for press and for release (>=2).
- HIST_DEPTH, 2, number of key codes retained in the history (>=1).
- REPEAT_DLY, 500000, cycles held before first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PER, 100000, cycles between later auto-repeats (AUTO_REPEAT_EN only).

Ports:
- int_osc  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- col_sync  in  COLS  synchronised columns, active-low (0 = key closed on driven row).
- r_sel  out  ROWS  row drive, active-low one-cold.
- key_code  out  KW = $clog2(ROWS*COLS)  code of last accepted key = row*COLS + col.
- key_valid  out  1  one-cycle strobe per accepted key.
- key_held  out  1  high from the key_valid cycle until release is debounced.
- hist  out  HIST_DEPTH*KW  code history; slot 0 = [KW-1:0] = newest.

Behaviour:
- Reset (synchronous, active-high, any state, takes effect on the next edge):
  - r_sel = ~1 (row 0 driven).
  - key_code = 0, key_valid = 0, key_held = 0, hist = 0.
  - State SCAN, all counters = 0.
- State SCAN:
  - Current row stays driven for SCAN_DIV cycles.
  - On the last dwell cycle (cnt == SCAN_DIV-1), if col_sync != all-ones: latch row index and the lowest-index low column, then go to DB_PRESS with cnt = 0.
  - Otherwise advance to the next row; row ROWS-1 wraps to row 0.
- State DB_PRESS:
  - Row is frozen.
  - While col_sync[latched col] == 0, cnt increments.
  - If that column reads 1 at any cycle, return to SCAN at the same row with a fresh dwell; no output.
  - When cnt reaches DEBOUNCE_CNT-1 with the column still low, go to HELD. In that same cycle:
    - key_valid = 1 and key_code is updated.
    - hist shifts: slot i <= slot i-1, slot 0 <= code, oldest slot discarded.
    - key_held = 1.
- State HELD:
  - Row frozen; other columns and rows are ignored (no n-key rollover).
  - When the latched column reads 1, go to DB_REL with cnt = 0.
- State DB_REL:
  - Counts consecutive cycles with the column high.
  - If the column returns low, go back to HELD with no new strobe (bounce absorbed).
  - At DEBOUNCE_CNT-1: key_held = 0 and return to SCAN at row (latched+1) mod ROWS.
- Output timing:
  - key_valid is never high for two consecutive cycles.
  - key_code and hist hold their values between presses.
- Simultaneous presses:
  - Same row: lowest column wins.
  - Different rows: the first row scanned wins.
- Latency: press accepted exactly SCAN_DIV-1-k + DEBOUNCE_CNT cycles after the column falls, where k is the dwell offset at the fall.
- Counters sized $clog2(max of active limits); no wrap is reachable.

Optional Feature:
- Macro KEYPAD_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - After REPEAT_DLY cycles, then every REPEAT_PER cycles, key_valid pulses with the same key_code and hist shifts.
  - The counter clears on leaving HELD. It pauses during DB_REL and resumes from its value if the key bounces back to HELD.
- Undefined: exactly one key_valid per press; REPEAT_* parameters are unused, with no logic generated.

Decomposition:
- Package keypad_pkg holds:
  - enum state_t {SCAN, DB_PRESS, HELD, DB_REL}.
  - Function kw(rows, cols) returning the code width.
  - Function lowest_zero(col vector) returning the column index.
- Sub-module keypad_stable_ctr, instantiated for the dwell counter and the debounce counter:
  - Counter with clear, enable, and a terminal-count flag at LIMIT-1.
  - Synchronous active-high reset.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CNT=3, HIST_DEPTH=2):
- Reset pulsed mid-DB_PRESS -> next cycle r_sel=4'b1110, key_valid=0, hist=0, key_held=0.
- col_sync=4'b1101 held while row 2 is driven -> one key_valid, key_code=2*4+1=9, key_held=1; r_sel stays 4'b1011 until release.
- Column low for 2 cycles then high (bounce shorter than DEBOUNCE_CNT) -> no key_valid; scan resumes on the same row.
- Press key 5, release, press key 10 -> hist[3:0]=10, hist[7:4]=5. A third press of key 0 -> hist={10,0}.
- While key 9 is held, toggle column high for 1 cycle -> no second key_valid; key_held stays 1.
- KEYPAD_AUTO_REPEAT_EN, REPEAT_DLY=10, REPEAT_PER=4, key held 30 cycles -> key_valid pulses at acceptance, then +10, +14, +18, … while held.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and elaboration-time helpers for the keypad scanner.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t      - scanner FSM states
//   MAX_COLS     - widest column bus lowest_zero() can search
//   ctr_w()      - bit width needed to count 0..limit-1
//   kw()         - key code width for a rows x cols matrix
//   lowest_zero()- index of the lowest active-low column
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    localparam int MAX_COLS = 32;

    // Width of a counter that must hold 0..limit-1.
    function automatic int ctr_w(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

    // Key code width: codes run 0..rows*cols-1.
    function automatic int kw(input int rows, input int cols);
        return ctr_w(rows * cols);
    endfunction

    // Lowest-index column reading 0 among the first ncols bits. Scanning
    // downwards lets the last hit (the lowest index) win. Returns 0 when no
    // column is low; callers only use it once a low column is known.
    function automatic int lowest_zero(input logic [MAX_COLS-1:0] cols_n,
                                       input int ncols);
        int idx;
        idx = 0;
        for (int i = MAX_COLS - 1; i >= 0; i--) begin
            if (i < ncols && !cols_n[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_stable_ctr.sv
// Up-counter with clear/enable and a terminal flag at LIMIT-1.
// Latency: tc is combinational from the count register.
// Backpressure: none; the caller stops enabling at terminal count.
//
// Ports:
//   core_clk - clock
//   reset    - synchronous, active-high
//   clr      - synchronous clear, wins over en
//   en       - count one step
//   tc       - count equals LIMIT-1
module keypad_stable_ctr
#(
    parameter int LIMIT = 4
) (
    input  logic core_clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    import keypad_pkg::*;

    localparam int W = ctr_w(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge core_clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_db.sv
// Row-scanning keypad reader with press/release debounce and a code history.
// Latency: key_valid rises SCAN_DIV-1-k+DEBOUNCE_CNT cycles after the column falls.
// Backpressure: none; key_valid is a one-cycle strobe, consumers must sample it.
//
// Ports:
//   int_osc   - clock
//   reset     - synchronous, active-high
//   col_sync  - synchronised columns, active-low (0 = key closed on driven row)
//   r_sel     - active-low one-cold row drive
//   key_code  - last accepted code, row*COLS + col
//   key_valid - one-cycle strobe per accepted key (and per repeat if enabled)
//   key_held  - high from acceptance until the release is debounced
//   hist      - HIST_DEPTH codes, slot 0 in [KW-1:0] is the newest
//
// Build option: define KEYPAD_AUTO_REPEAT_EN to emit repeat strobes while a
// key stays held (first after REPEAT_DLY cycles, then every REPEAT_PER).
module keypad_scan_db
    import keypad_pkg::*;
#(
    parameter  int ROWS         = 4,
    parameter  int COLS         = 4,
    parameter  int SCAN_DIV     = 1000,
    parameter  int DEBOUNCE_CNT = 20000,
    parameter  int HIST_DEPTH   = 2,
    parameter  int REPEAT_DLY   = 500000,
    parameter  int REPEAT_PER   = 100000,
    localparam int KW           = kw(ROWS, COLS)
) (
    input  logic                     int_osc,
    input  logic                     reset,
    input  logic [COLS-1:0]          col_sync,
    output logic [ROWS-1:0]          r_sel,
    output logic [KW-1:0]            key_code,
    output logic                     key_valid,
    output logic                     key_held,
    output logic [HIST_DEPTH*KW-1:0] hist
);

    localparam int RW = ctr_w(ROWS);
    localparam int CW = ctr_w(COLS);
    localparam int HW = HIST_DEPTH * KW;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    // Elaboration-time parameter sanity.
    if (ROWS < 2 || COLS < 2 || COLS > MAX_COLS) begin : g_bad_geom
        $error("keypad_scan_db: ROWS/COLS out of range");
    end
    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || HIST_DEPTH < 1) begin : g_bad_timing
        $error("keypad_scan_db: SCAN_DIV/DEBOUNCE_CNT/HIST_DEPTH out of range");
    end
    if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_repeat
        $error("keypad_scan_db: REPEAT_DLY/REPEAT_PER out of range");
    end

    state_t         state, state_nxt;
    logic [RW-1:0]  row_q, row_nxt, row_inc;
    logic [CW-1:0]  lcol_q, lcol_nxt;
    logic           dwell_clr, dwell_en, dwell_tc;
    logic           db_clr, db_en, db_tc;
    logic           accept, release_done, rpt_fire, emit;
    logic           col_lat, any_low;
    logic [KW-1:0]  code_nxt;

    // Row dwell timer and press/release stability timer.
    keypad_stable_ctr #(.LIMIT(SCAN_DIV)) u_dwell_ctr (
        .core_clk (int_osc),
        .reset    (reset),
        .clr      (dwell_clr),
        .en       (dwell_en),
        .tc       (dwell_tc)
    );

    keypad_stable_ctr #(.LIMIT(DEBOUNCE_CNT)) u_db_ctr (
        .core_clk (int_osc),
        .reset    (reset),
        .clr      (db_clr),
        .en       (db_en),
        .tc       (db_tc)
    );

    // Level of the column captured at detection; the only input the
    // debouncers look at, so other keys are ignored until the scan resumes.
    assign col_lat = col_sync[lcol_q];
    assign any_low = ~&col_sync;
    assign row_inc = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);

    always_comb begin
        state_nxt    = state;
        row_nxt      = row_q;
        lcol_nxt     = lcol_q;
        dwell_clr    = 1'b0;
        dwell_en     = 1'b0;
        db_clr       = 1'b0;
        db_en        = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        case (state)
            SCAN: begin
                dwell_en = 1'b1;
                if (dwell_tc) begin
                    // Both timers start fresh for whatever comes next.
                    dwell_clr = 1'b1;
                    db_clr    = 1'b1;
                    if (any_low) begin
                        state_nxt = DB_PRESS;
                        lcol_nxt  = CW'(lowest_zero(MAX_COLS'(col_sync), COLS));
                    end else begin
                        row_nxt = row_inc;
                    end
                end
            end
            DB_PRESS: begin
                if (col_lat) begin
                    // Too short: rescan the same row from a fresh dwell.
                    state_nxt = SCAN;
                    dwell_clr = 1'b1;
                end else if (db_tc) begin
                    state_nxt = HELD;
                    accept    = 1'b1;
                end else begin
                    db_en = 1'b1;
                end
            end
            HELD: begin
                if (col_lat) begin
                    state_nxt = DB_REL;
                    db_clr    = 1'b1;
                end
            end
            DB_REL: begin
                if (!col_lat) begin
                    // Release bounce: back to HELD without a new strobe.
                    state_nxt = HELD;
                end else if (db_tc) begin
                    state_nxt    = SCAN;
                    release_done = 1'b1;
                    dwell_clr    = 1'b1;
                    row_nxt      = row_inc;
                end else begin
                    db_en = 1'b1;
                end
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPW     = ctr_w(RPT_MAX);

    logic [RPW-1:0] rpt_cnt;
    logic           rpt_again;
    logic           rpt_run;
    logic           rpt_hit;

    // Counts only cycles spent in HELD with the key still down, so the
    // count naturally pauses across a release bounce through DB_REL.
    assign rpt_run  = (state == HELD) && !col_lat;
    assign rpt_hit  = rpt_again ? (rpt_cnt == RPW'(REPEAT_PER - 1))
                                : (rpt_cnt == RPW'(REPEAT_DLY - 1));
    assign rpt_fire = rpt_run && rpt_hit;

    always_ff @(posedge int_osc) begin
        if (reset || release_done || accept) begin
            rpt_cnt   <= '0;
            rpt_again <= 1'b0;
        end else if (rpt_run) begin
            if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_again <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + RPW'(1);
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign emit     = accept | rpt_fire;
    // A repeat re-sends the held code; accept builds the new one.
    assign code_nxt = accept ? (KW'(row_q) * KW'(COLS) + KW'(lcol_q)) : key_code;

    always_ff @(posedge int_osc) begin
        if (reset) begin
            state     <= SCAN;
            row_q     <= '0;
            lcol_q    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            hist      <= '0;
        end else begin
            state     <= state_nxt;
            row_q     <= row_nxt;
            lcol_q    <= lcol_nxt;
            key_valid <= emit;
            if (emit) begin
                key_code <= code_nxt;
                hist     <= (hist << KW) | HW'(code_nxt);
            end
            if (accept) begin
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

    assign r_sel = ~(ROWS'(1) << row_q);

endmodule
